// File: rtl/game_over_pkg.sv
// Shared types and constants for the game-over animation sequencer.
// Included by the phase timer and the sequencer top.
package game_over_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        SPLIT,
        FALL,
        FADE,
        DONE
    } go_state_t;

    localparam logic [1:0] PHASE_HOLD  = 2'd0;
    localparam logic [1:0] PHASE_SPLIT = 2'd1;
    localparam logic [1:0] PHASE_FALL  = 2'd2;
    localparam logic [1:0] PHASE_FADE  = 2'd3;

    localparam int FONT_W  = 12;
    localparam int TIMER_W = 32;

endpackage

// File: rtl/game_over_sequencer_phase_timer.sv
// Restartable cycle timer with a runtime terminal count.
// Counts 0..limit-1 while enabled and self-clears on the terminal cycle.
module phase_timer
    import game_over_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [TIMER_W-1:0] i_limit,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    assign o_done = i_en && (r_count == i_limit - TIMER_W'(1));

    // Count while enabled; wrap to zero on the terminal cycle or on clear
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            if (o_done) r_count <= '0;
            else        r_count <= r_count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/game_over_sequencer.sv
// Game-over animation controller: hold, split, fall-apart, text fade-in.
// Drives heart sprite selects and a grey font colour ramp.
module game_over_sequencer
    import game_over_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 65_000_000,
    parameter int unsigned SPLIT_CYCLES = 130_000_000,
    parameter int unsigned FALL_CYCLES  = 65_000_000,
    parameter int unsigned FADE_FRAMES  = 64,
    parameter int unsigned FADE_MAX     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    output logic              busy_out,
    output logic              finished_out,
    output logic [1:0]        phase_out,
    output logic              divided_out,
    output logic              fall_apart_valid_out,
    output logic [FONT_W-1:0] font_color_out
);

    localparam int FC_W = $clog2(FADE_FRAMES + 1);

    go_state_t          r_state;
    logic [FC_W-1:0]    r_frame_cnt;
    logic [3:0]         r_lvl;
    logic               r_finished;

    logic               w_frame_tick;
    logic               w_timed;
    logic               w_t_done;
    logic [TIMER_W-1:0] w_limit;
    logic               w_fc_last;
    logic [3:0]         w_lvl_inc;
    logic               w_lvl_last;

    assign w_frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign w_timed      = (r_state == HOLD) || (r_state == SPLIT) ||
                          (r_state == FALL);
    assign w_fc_last    = (TIMER_W'(r_frame_cnt) == FADE_FRAMES - 1);
    assign w_lvl_inc    = r_lvl + 4'd1;
    assign w_lvl_last   = (TIMER_W'(w_lvl_inc) == FADE_MAX);

    // Select the duration of the current timed phase
    always_comb begin
        w_limit = '0;
        case (r_state)
            HOLD:    w_limit = HOLD_CYCLES;
            SPLIT:   w_limit = SPLIT_CYCLES;
            FALL:    w_limit = FALL_CYCLES;
            default: w_limit = '0;
        endcase
    end

    phase_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (~w_timed),
        .i_en    (w_timed),
        .i_limit (w_limit),
        .o_done  (w_t_done)
    );

    // Phase sequencing, frame counting and fade level ramp
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            r_lvl       <= 4'd0;
            r_finished  <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_in) r_state <= HOLD;
                end
                HOLD: begin
                    if (w_t_done) r_state <= SPLIT;
                end
                SPLIT: begin
                    if (w_t_done) r_state <= FALL;
                end
                FALL: begin
                    if (w_t_done) begin
                        r_state     <= FADE;
                        r_frame_cnt <= '0;
                    end
                end
                FADE: begin
                    if (w_frame_tick) begin
                        if (w_fc_last) begin
                            r_frame_cnt <= '0;
                            r_lvl       <= w_lvl_inc;
                            if (w_lvl_last) begin
                                r_state    <= DONE;
                                r_finished <= 1'b1;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FC_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (start_in) begin
                        r_state     <= HOLD;
                        r_lvl       <= 4'd0;
                        r_frame_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore decode of the phase index for the pixel mux
    always_comb begin
        phase_out = PHASE_HOLD;
        case (r_state)
            SPLIT:   phase_out = PHASE_SPLIT;
            FALL:    phase_out = PHASE_FALL;
            FADE:    phase_out = PHASE_FADE;
            DONE:    phase_out = PHASE_FADE;
            default: phase_out = PHASE_HOLD;
        endcase
    end

    assign busy_out             = w_timed || (r_state == FADE);
    assign divided_out          = (r_state == SPLIT) || (r_state == FALL) ||
                                  (r_state == FADE)  || (r_state == DONE);
    assign fall_apart_valid_out = (r_state == FALL) || (r_state == FADE) ||
                                  (r_state == DONE);
    assign finished_out         = r_finished;
    assign font_color_out       = {r_lvl, r_lvl, r_lvl};

endmodule

// File: tb/tb_game_over_sequencer.sv
// Directed, table-driven bench for game_over_sequencer.
// Small phase lengths; frame ticks land on every edge that is a multiple of 5.
module tb_game_over_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [10:0] hcount_in = 11'd7;
    logic [9:0]  vcount_in = 10'd0;
    logic        busy_out;
    logic        finished_out;
    logic [1:0]  phase_out;
    logic        divided_out;
    logic        fall_apart_valid_out;
    logic [11:0] font_color_out;

    game_over_sequencer #(
        .HOLD_CYCLES  (4),
        .SPLIT_CYCLES (3),
        .FALL_CYCLES  (2),
        .FADE_FRAMES  (2),
        .FADE_MAX     (3)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_in             (start_in),
        .hcount_in            (hcount_in),
        .vcount_in            (vcount_in),
        .busy_out             (busy_out),
        .finished_out         (finished_out),
        .phase_out            (phase_out),
        .divided_out          (divided_out),
        .fall_apart_valid_out (fall_apart_valid_out),
        .font_color_out       (font_color_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       r;
        logic       st;
        logic       busy;
        logic       fin;
        logic [1:0] ph;
        logic       div;
        logic       fav;
        logic [11:0] font;
    } vec_t;

    vec_t tbl[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   fin_seen = 0;

    function automatic void add(int n, logic r, logic st, logic busy,
                                logic fin, logic [1:0] ph, logic div,
                                logic fav, logic [11:0] font);
        vec_t v;
        v.n = n; v.r = r; v.st = st; v.busy = busy; v.fin = fin;
        v.ph = ph; v.div = div; v.fav = fav; v.font = font;
        tbl.push_back(v);
    endfunction

    // Normal run from a start sampled at an edge that is 0 mod 5
    function automatic void add_run();
        add(4,  0, 1, 1, 0, 2'd0, 0, 0, 12'h000);
        add(3,  0, 0, 1, 0, 2'd1, 1, 0, 12'h000);
        add(2,  0, 0, 1, 0, 2'd2, 1, 1, 12'h000);
        add(6,  0, 0, 1, 0, 2'd3, 1, 1, 12'h000);
        add(10, 0, 0, 1, 0, 2'd3, 1, 1, 12'h111);
        add(10, 0, 0, 1, 0, 2'd3, 1, 1, 12'h222);
        add(1,  0, 0, 0, 1, 2'd3, 1, 1, 12'h333);
    endfunction

    task automatic step(input logic r, input logic st);
        rst      = r;
        start_in = st;
        if ((cyc + 1) % 5 == 0) begin
            hcount_in = 11'd0;
            vcount_in = 10'd0;
        end else if (cyc % 2 == 1) begin
            hcount_in = 11'd0;
            vcount_in = 10'd5;
        end else begin
            hcount_in = 11'd7;
            vcount_in = 10'd0;
        end
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    initial begin
        logic [17:0] got;
        logic [17:0] exp;

        // reset, idle
        add(3, 1, 0, 0, 0, 2'd0, 0, 0, 12'h000);
        add(6, 0, 0, 0, 0, 2'd0, 0, 0, 12'h000);
        // run A: start at edge 10, then long DONE hold
        add_run();
        add(1000, 0, 0, 0, 0, 2'd3, 1, 1, 12'h333);
        // run B: restart from DONE at 1046; starts ignored in SPLIT and FADE;
        // FALL expiry at 1055 coincides with a frame tick
        add(4,  0, 1, 1, 0, 2'd0, 0, 0, 12'h000);
        add(1,  0, 0, 1, 0, 2'd1, 1, 0, 12'h000);
        add(2,  0, 1, 1, 0, 2'd1, 1, 0, 12'h000);
        add(2,  0, 0, 1, 0, 2'd2, 1, 1, 12'h000);
        add(5,  0, 0, 1, 0, 2'd3, 1, 1, 12'h000);
        add(5,  0, 1, 1, 0, 2'd3, 1, 1, 12'h000);
        add(10, 0, 0, 1, 0, 2'd3, 1, 1, 12'h111);
        add(10, 0, 0, 1, 0, 2'd3, 1, 1, 12'h222);
        add(1,  0, 0, 0, 1, 2'd3, 1, 1, 12'h333);
        add(5,  0, 0, 0, 0, 2'd3, 1, 1, 12'h333);
        // run C: restart at 1091, reset mid-FALL
        add(4,  0, 1, 1, 0, 2'd0, 0, 0, 12'h000);
        add(3,  0, 0, 1, 0, 2'd1, 1, 0, 12'h000);
        add(1,  0, 0, 1, 0, 2'd2, 1, 1, 12'h000);
        add(1,  1, 0, 0, 0, 2'd0, 0, 0, 12'h000);
        add(10, 0, 0, 0, 0, 2'd0, 0, 0, 12'h000);
        // run D: replay of run A timing from edge 1110
        add_run();
        // reset wins over start
        add(1,  1, 1, 0, 0, 2'd0, 0, 0, 12'h000);
        add(3,  0, 0, 0, 0, 2'd0, 0, 0, 12'h000);

        foreach (tbl[ri]) begin
            for (int i = 0; i < tbl[ri].n; i++) begin
                step(tbl[ri].r, (i == 0) ? tbl[ri].st : 1'b0);
                got = {busy_out, finished_out, phase_out, divided_out,
                       fall_apart_valid_out, font_color_out};
                exp = {tbl[ri].busy, tbl[ri].fin, tbl[ri].ph, tbl[ri].div,
                       tbl[ri].fav, tbl[ri].font};
                if (finished_out) fin_seen = fin_seen + 1;
                checks = checks + 1;
                if (got !== exp) begin
                    failures = failures + 1;
                    $display("FAIL row%0d edge%0d outputs got=%h exp=%h",
                             ri, cyc, got, exp);
                end
            end
        end

        checks = checks + 1;
        if (fin_seen != 3) begin
            failures = failures + 1;
            $display("FAIL finished_pulses got=%0d exp=3", fin_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
